// File: rtl/flag_window_stats.sv
// flag_window_stats: counts occurrences of four nibble-classifier flags over a
// window of WINDOW accepted samples, then presents the counts as a report
// held under a valid/ready handshake.
module flag_window_stats #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic          flag_even,
    input  logic          flag_odd,
    input  logic          flag_zero,
    input  logic          flag_ones,
    output logic [CW-1:0] cnt_even,
    output logic [CW-1:0] cnt_odd,
    output logic [CW-1:0] cnt_zero,
    output logic [CW-1:0] cnt_ones,
    output logic          rpt_valid,
    input  logic          rpt_ready,
    output logic          busy
);

    // Sample counter is sized for the largest legal window (255).
    localparam int unsigned SW = 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;

    localparam logic [SW-1:0] LAST_IDX = SW'(WINDOW - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [SW-1:0] sample_cnt;
    logic [SW-1:0] sample_nxt;
    logic [CW-1:0] even_nxt;
    logic [CW-1:0] odd_nxt;
    logic [CW-1:0] zero_nxt;
    logic [CW-1:0] ones_nxt;
    logic          rpt_valid_nxt;
    logic          busy_nxt;

    // Saturating increment: a count that reaches its maximum stays there.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic f);
        return (f && (v != CNT_MAX)) ? v + CW'(1) : v;
    endfunction

    // Next-state, counter and output-flag logic.
    always_comb begin
        state_nxt  = state;
        sample_nxt = sample_cnt;
        even_nxt   = cnt_even;
        odd_nxt    = cnt_odd;
        zero_nxt   = cnt_zero;
        ones_nxt   = cnt_ones;

        case (state)
            S_IDLE: begin
                // abort has no effect here, so start alone decides.
                if (start) begin
                    state_nxt  = S_COLLECT;
                    sample_nxt = '0;
                    even_nxt   = '0;
                    odd_nxt    = '0;
                    zero_nxt   = '0;
                    ones_nxt   = '0;
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    state_nxt  = S_IDLE;
                    sample_nxt = '0;
                    even_nxt   = '0;
                    odd_nxt    = '0;
                    zero_nxt   = '0;
                    ones_nxt   = '0;
                end else if (in_valid) begin
                    sample_nxt = sample_cnt + SW'(1);
                    even_nxt   = sat_inc(cnt_even, flag_even);
                    odd_nxt    = sat_inc(cnt_odd,  flag_odd);
                    zero_nxt   = sat_inc(cnt_zero, flag_zero);
                    ones_nxt   = sat_inc(cnt_ones, flag_ones);
                    if (sample_cnt == LAST_IDX) begin
                        state_nxt = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (abort) begin
                    state_nxt  = S_IDLE;
                    sample_nxt = '0;
                    even_nxt   = '0;
                    odd_nxt    = '0;
                    zero_nxt   = '0;
                    ones_nxt   = '0;
                end else if (rpt_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        rpt_valid_nxt = (state_nxt == S_REPORT);
        busy_nxt      = (state_nxt != S_IDLE);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            cnt_even   <= '0;
            cnt_odd    <= '0;
            cnt_zero   <= '0;
            cnt_ones   <= '0;
            rpt_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= sample_nxt;
            cnt_even   <= even_nxt;
            cnt_odd    <= odd_nxt;
            cnt_zero   <= zero_nxt;
            cnt_ones   <= ones_nxt;
            rpt_valid  <= rpt_valid_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_flag_window_stats.sv
// Testbench for flag_window_stats: directed vector table, hand-written corner
// sequences (saturation, async reset) and randomized traffic against a
// queue-based reference model.
module tb_flag_window_stats;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst_n;

    // Main instance (WINDOW=4, CW=8)
    logic          start, abort, in_valid, rpt_ready;
    logic          flag_even, flag_odd, flag_zero, flag_ones;
    logic [CW-1:0] cnt_even, cnt_odd, cnt_zero, cnt_ones;
    logic          rpt_valid, busy;

    // Saturation instance (WINDOW=255, CW=4)
    logic       s_start, s_abort, s_in_valid, s_rpt_ready;
    logic       s_even, s_odd, s_zero, s_ones;
    logic [3:0] s_cnt_even, s_cnt_odd, s_cnt_zero, s_cnt_ones;
    logic       s_rpt_valid, s_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    flag_window_stats #(.WINDOW(W), .CW(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .flag_even(flag_even), .flag_odd(flag_odd),
        .flag_zero(flag_zero), .flag_ones(flag_ones),
        .cnt_even(cnt_even), .cnt_odd(cnt_odd), .cnt_zero(cnt_zero),
        .cnt_ones(cnt_ones), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .busy(busy)
    );

    flag_window_stats #(.WINDOW(255), .CW(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .in_valid(s_in_valid), .flag_even(s_even), .flag_odd(s_odd),
        .flag_zero(s_zero), .flag_ones(s_ones),
        .cnt_even(s_cnt_even), .cnt_odd(s_cnt_odd), .cnt_zero(s_cnt_zero),
        .cnt_ones(s_cnt_ones), .rpt_valid(s_rpt_valid), .rpt_ready(s_rpt_ready),
        .busy(s_busy)
    );

    typedef struct {
        logic       st;
        logic       ab;
        logic       iv;
        logic [3:0] fl;   // {even, odd, zero, ones}
        logic       rd;
        logic       rv;
        logic       bz;
        int         e;
        int         o;
        int         z;
        int         n;
    } vec_t;

    vec_t tbl[$];

    // Reference model: phase 0=idle 1=collect 2=report; the accepted samples
    // of the current window are kept verbatim and counted on demand.
    int         m_phase;
    logic [3:0] m_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_main(input string tag, input logic rv, input logic bz,
                            input int e, input int o, input int z, input int n);
        chk({tag, ".rpt_valid"}, int'(rpt_valid), int'(rv));
        chk({tag, ".busy"},      int'(busy),      int'(bz));
        chk({tag, ".cnt_even"},  int'(cnt_even),  e);
        chk({tag, ".cnt_odd"},   int'(cnt_odd),   o);
        chk({tag, ".cnt_zero"},  int'(cnt_zero),  z);
        chk({tag, ".cnt_ones"},  int'(cnt_ones),  n);
    endtask

    task automatic drive(input logic st, input logic ab, input logic iv,
                         input logic [3:0] fl, input logic rd);
        start     = st;
        abort     = ab;
        in_valid  = iv;
        flag_even = fl[3];
        flag_odd  = fl[2];
        flag_zero = fl[1];
        flag_ones = fl[0];
        rpt_ready = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic ab, input logic iv, input logic [3:0] fl,
                       input logic rd, input logic rv, input logic bz,
                       input int e, input int o, input int z, input int n);
        vec_t v;
        v.st = st; v.ab = ab; v.iv = iv; v.fl = fl; v.rd = rd;
        v.rv = rv; v.bz = bz; v.e = e; v.o = o; v.z = z; v.n = n;
        tbl.push_back(v);
    endtask

    function automatic int mcount(input int b);
        int c = 0;
        foreach (m_q[i]) c += int'(m_q[i][b]);
        return (c > 255) ? 255 : c;
    endfunction

    task automatic model_step(input logic st, input logic ab, input logic iv,
                              input logic [3:0] fl, input logic rd);
        if (m_phase == 0) begin
            if (st) begin
                m_phase = 1;
                m_q.delete();
            end
        end else if (ab) begin
            m_phase = 0;
            m_q.delete();
        end else if (m_phase == 1) begin
            if (iv) begin
                m_q.push_back(fl);
                if (m_q.size() == W) m_phase = 2;
            end
        end else if (rd) begin
            m_phase = 0;
        end
    endtask

    initial begin
        logic st, ab, iv, rd;
        logic [3:0] fl;

        rst_n = 1'b0;
        drive(0, 0, 0, 4'b0000, 0);
        s_start = 0; s_abort = 0; s_in_valid = 0; s_rpt_ready = 0;
        s_even = 0; s_odd = 0; s_zero = 0; s_ones = 0;
        #2;
        chk_main("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.sat_busy", int'(s_busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // st ab iv flags rd | rv bz even odd zero ones
        // basic window; the start-cycle sample is ignored
        add(1,0,1,4'b1111,0, 0,1, 0,0,0,0);
        add(0,0,1,4'b1010,0, 0,1, 1,0,1,0);
        add(0,0,1,4'b0100,0, 0,1, 1,1,1,0);
        add(0,0,1,4'b1001,0, 0,1, 2,1,1,1);
        add(0,0,1,4'b0100,0, 1,1, 2,2,1,1);
        add(0,0,0,4'b0000,1, 0,0, 2,2,1,1);
        add(0,0,1,4'b1111,1, 0,0, 2,2,1,1);
        // gaps and backpressure
        add(1,0,0,4'b0000,0, 0,1, 0,0,0,0);
        add(0,0,1,4'b1111,0, 0,1, 1,1,1,1);
        add(0,0,0,4'b1111,0, 0,1, 1,1,1,1);
        add(0,0,0,4'b1111,0, 0,1, 1,1,1,1);
        add(0,0,0,4'b1111,0, 0,1, 1,1,1,1);
        add(0,0,1,4'b1000,0, 0,1, 2,1,1,1);
        add(0,0,0,4'b0000,0, 0,1, 2,1,1,1);
        add(0,0,1,4'b0010,0, 0,1, 2,1,2,1);
        add(0,0,1,4'b0001,0, 1,1, 2,1,2,2);
        for (int i = 0; i < 5; i++) add(1,0,1,4'b1111,0, 1,1, 2,1,2,2);
        add(0,0,0,4'b0000,1, 0,0, 2,1,2,2);
        // abort in collect, abort in idle, start+abort, abort with ready
        add(1,0,0,4'b0000,0, 0,1, 0,0,0,0);
        add(0,0,1,4'b1111,0, 0,1, 1,1,1,1);
        add(0,0,1,4'b1100,0, 0,1, 2,2,1,1);
        add(0,1,1,4'b1111,0, 0,0, 0,0,0,0);
        add(0,1,0,4'b0000,0, 0,0, 0,0,0,0);
        add(1,1,0,4'b0000,0, 0,1, 0,0,0,0);
        add(0,0,1,4'b1000,0, 0,1, 1,0,0,0);
        add(0,0,1,4'b1000,0, 0,1, 2,0,0,0);
        add(0,0,1,4'b1000,0, 0,1, 3,0,0,0);
        add(0,0,1,4'b1000,0, 1,1, 4,0,0,0);
        add(0,1,0,4'b0000,1, 0,0, 0,0,0,0);
        // start ignored during collect
        add(1,0,0,4'b0000,0, 0,1, 0,0,0,0);
        add(0,0,1,4'b0100,0, 0,1, 0,1,0,0);
        add(1,0,1,4'b0100,0, 0,1, 0,2,0,0);
        add(1,0,0,4'b0000,0, 0,1, 0,2,0,0);
        add(0,0,1,4'b0100,0, 0,1, 0,3,0,0);
        add(0,0,1,4'b0100,0, 1,1, 0,4,0,0);
        add(0,0,0,4'b0000,1, 0,0, 0,4,0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].ab, tbl[i].iv, tbl[i].fl, tbl[i].rd);
            step();
            chk_main($sformatf("vec%0d", i), tbl[i].rv, tbl[i].bz,
                     tbl[i].e, tbl[i].o, tbl[i].z, tbl[i].n);
        end
        drive(0, 0, 0, 4'b0000, 0);

        // saturation: 255 even-flagged samples into a 4-bit counter
        s_start = 1;
        step();
        s_start = 0; s_in_valid = 1; s_even = 1;
        for (int i = 0; i < 254; i++) step();
        chk("sat.pre_rpt_valid", int'(s_rpt_valid), 0);
        chk("sat.pre_cnt_even", int'(s_cnt_even), 15);
        step();
        s_in_valid = 0; s_even = 0;
        chk("sat.rpt_valid", int'(s_rpt_valid), 1);
        chk("sat.cnt_even", int'(s_cnt_even), 15);
        chk("sat.cnt_odd", int'(s_cnt_odd), 0);
        chk("sat.cnt_zero", int'(s_cnt_zero), 0);
        chk("sat.cnt_ones", int'(s_cnt_ones), 0);
        s_rpt_ready = 1;
        step();
        s_rpt_ready = 0;
        chk("sat.done_rpt_valid", int'(s_rpt_valid), 0);
        chk("sat.done_busy", int'(s_busy), 0);
        chk("sat.hold_cnt_even", int'(s_cnt_even), 15);

        // asynchronous reset mid-collect
        drive(1, 0, 0, 4'b0000, 0);
        step();
        drive(0, 0, 1, 4'b1111, 0);
        step();
        step();
        chk_main("arst.pre", 0, 1, 2, 2, 2, 2);
        drive(0, 0, 0, 4'b0000, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_main("arst.now", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_main("arst.idle", 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 4'b0000, 0);
        step();
        drive(0, 0, 1, 4'b0001, 0);
        for (int i = 0; i < 3; i++) step();
        chk_main("arst.win3", 0, 1, 0, 0, 0, 3);
        step();
        chk_main("arst.win4", 1, 1, 0, 0, 0, 4);
        drive(0, 0, 0, 4'b0000, 1);
        step();
        chk_main("arst.ack", 0, 0, 0, 0, 0, 4);

        // randomized traffic against the reference model, from a fresh reset
        drive(0, 0, 0, 4'b0000, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_phase = 0;
        m_q.delete();
        for (int c = 0; c < 2000; c++) begin
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 29) == 0);
            iv = ($urandom_range(0, 9) < 6);
            fl = 4'($urandom);
            rd = ($urandom_range(0, 2) == 0);
            drive(st, ab, iv, fl, rd);
            model_step(st, ab, iv, fl, rd);
            step();
            chk_main($sformatf("rand%0d", c), m_phase == 2, m_phase != 0,
                     mcount(3), mcount(2), mcount(1), mcount(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flag_window_stats.md
FLAG_WINDOW_STATS -- requirements
Module: flag_window_stats

Interface
REQ-001 SHALL have parameter WINDOW, default 16, meaning the number of accepted samples per measurement window (legal range 1..255).
REQ-002 SHALL have parameter CW, default 8, meaning the width of each occurrence counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a new window.
REQ-006 SHALL have port abort, input, 1, which cancels the current window or report.
REQ-007 SHALL have port in_valid, input, 1, which qualifies the four flag inputs this cycle.
REQ-008 SHALL have port flag_even, input, 1, the even-parity flag from the nibble classifier.
REQ-009 SHALL have port flag_odd, input, 1, the odd-parity flag from the nibble classifier.
REQ-010 SHALL have port flag_zero, input, 1, the all-zero flag from the nibble classifier.
REQ-011 SHALL have port flag_ones, input, 1, the all-ones flag from the nibble classifier.
REQ-012 SHALL have ports cnt_even, cnt_odd, cnt_zero, cnt_ones, output, CW each, the per-flag occurrence counts.
REQ-013 SHALL have port rpt_valid, output, 1, which asserts while the counts form a complete report.
REQ-014 SHALL have port rpt_ready, input, 1, the consumer's acceptance of the report.
REQ-015 SHALL have port busy, output, 1, which is high in the COLLECT and REPORT states.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, COLLECT, REPORT; all outputs SHALL be registered.
REQ-017 IDLE: start=1 SHALL transition to COLLECT and clear all four counts and the internal sample counter on the same edge.
REQ-018 The flag inputs present in the cycle start is sampled SHALL NOT be counted; counting begins the following cycle.
REQ-019 The start input SHALL be ignored in COLLECT and REPORT.
REQ-020 COLLECT: each cycle with in_valid=1 SHALL increment the sample counter by 1 and increment each count whose flag is 1; more than one count may increment in a cycle.
REQ-021 COLLECT: cycles with in_valid=0 SHALL leave all counters unchanged.
REQ-022 Each count SHALL saturate at 2^CW-1 and never wrap.
REQ-023 Acceptance of the WINDOW-th valid sample SHALL move the FSM to REPORT on that edge, so rpt_valid is high in the following cycle; that sample's flags SHALL be included in the counts.
REQ-024 REPORT: rpt_valid=1 and all counts SHALL remain stable until a cycle with rpt_ready=1.
REQ-025 REPORT: in_valid SHALL be ignored.
REQ-026 REPORT: rpt_valid&rpt_ready SHALL transition to IDLE, with rpt_valid low the next cycle.
REQ-027 After the report is accepted, the counts SHALL hold their values in IDLE until the next start.
REQ-028 The abort input SHALL take priority over every other input: in COLLECT or REPORT it SHALL return the FSM to IDLE, clear all counts, and force rpt_valid=0 next cycle.
REQ-029 In IDLE, abort SHALL have no effect, and abort together with start in IDLE SHALL be treated as start.
REQ-030 When abort and rpt_ready are both high in REPORT, the report SHALL be discarded (abort wins).
REQ-031 rpt_ready outside REPORT SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, all counts=0, the sample counter=0, rpt_valid=0 and busy=0.
REQ-033 Reset asserted mid-COLLECT or mid-REPORT SHALL discard all progress; after release the block SHALL wait in IDLE for start.

Verification (WINDOW=4, CW=8)
REQ-034 Scenario 1 SHALL cover the basic window: start, then 4 valid samples with flags {even,zero}, {odd}, {even,ones}, {odd} -> rpt_valid high 1 cycle after the 4th sample; even=2, odd=2, zero=1, ones=1.
REQ-035 Scenario 2 SHALL cover gaps and backpressure: in_valid low for 3 cycles between samples, rpt_ready held low 5 cycles -> counts unchanged during the gaps; rpt_valid and counts stable for all 5 cycles; IDLE 1 cycle after rpt_ready.
REQ-036 Scenario 3 SHALL cover saturation: WINDOW=255, CW=4, flag_even=1 on every sample -> cnt_even=15 at report; no wrap.
REQ-037 Scenario 4 SHALL cover abort: abort after 2 samples -> IDLE, all counts 0, busy=0; abort with rpt_ready in REPORT -> report discarded, counts 0.
REQ-038 Scenario 5 SHALL cover ignored inputs: start during COLLECT, a valid sample in the start cycle, in_valid during REPORT -> none of them alter the counts or the FSM state.
REQ-039 Scenario 6 SHALL cover asynchronous reset: rst_n pulsed low between clock edges mid-COLLECT -> outputs 0 immediately; the next start runs a clean window.
